// File: rtl/rgb_frame_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rgb_frame_loader_pkg
// Purpose  : Constants, state encoding and helper functions shared by the
//            frame-buffer write side and the vga_controller read side.
// Revision : 1.0 - initial release
// ============================================================================
package rgb_frame_loader_pkg;

    localparam int DEFAULT_IMG_W      = 160;
    localparam int DEFAULT_IMG_H      = 120;
    localparam int DEFAULT_COLOR_BITS = 4;
    localparam int FRAME_PIXELS       = DEFAULT_IMG_W * DEFAULT_IMG_H;
    localparam int PIXEL_W            = 3 * DEFAULT_COLOR_BITS;

    // Loader state: which channel byte is expected next, or frame complete
    typedef enum logic [1:0] {
        RX_R = 2'd0,
        RX_G = 2'd1,
        RX_B = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic int frame_pixels(input int img_w, input int img_h);
        return img_w * img_h;
    endfunction

    function automatic int pixel_width(input int color_bits);
        return 3 * color_bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rgb_frame_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : rgb_frame_loader_if
// Purpose  : Byte-stream input and RAM-write/status output bundle of the
//            frame loader. master = byte source / RAM side, slave = loader.
// Revision : 1.0 - initial release
// ============================================================================
interface rgb_frame_loader_if #(
    parameter int ADDR_W     = 15,
    parameter int COLOR_BITS = 4
);

    logic                      i_Rx_DV;
    logic [7:0]                i_Rx_Byte;
    logic                      i_Start;
    logic                      o_Wr_En;
    logic [ADDR_W-1:0]         o_Wr_Addr;
    logic [3*COLOR_BITS-1:0]   o_Wr_Data;
    logic                      o_Busy;
    logic                      o_Frame_Done;
    logic                      o_Sync_Err;
    logic                      o_LED_Activity;

    modport master (
        output i_Rx_DV, i_Rx_Byte, i_Start,
        input  o_Wr_En, o_Wr_Addr, o_Wr_Data, o_Busy, o_Frame_Done,
               o_Sync_Err, o_LED_Activity
    );

    modport slave (
        input  i_Rx_DV, i_Rx_Byte, i_Start,
        output o_Wr_En, o_Wr_Addr, o_Wr_Data, o_Busy, o_Frame_Done,
               o_Sync_Err, o_LED_Activity
    );

endinterface
`default_nettype wire

// File: rtl/rgb_frame_loader_activity_stretch.sv
`default_nettype none
// ============================================================================
// Module   : activity_stretch
// Purpose  : Reloadable down-counter that stretches single-cycle pulses into
//            a HOLD_CLKS-long active level (board LED driver).
// Revision : 1.0 - initial release
// ============================================================================
module activity_stretch #(
    parameter int HOLD_CLKS = 2500000
) (
    input  logic i_Clock,
    input  logic i_Reset_n,
    input  logic i_Pulse,
    output logic o_Active
);

    // +1 so that the reload value itself always fits, even for powers of two
    localparam int c_CNT_W = $clog2(HOLD_CLKS + 1);
    localparam logic [c_CNT_W-1:0] c_RELOAD = c_CNT_W'(HOLD_CLKS);

    logic [c_CNT_W-1:0] r_cnt;

    // Reload on every pulse, otherwise count down to zero and stop
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_cnt <= '0;
        end else if (i_Pulse) begin
            r_cnt <= c_RELOAD;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - c_CNT_W'(1);
        end
    end

    assign o_Active = (r_cnt != '0);

endmodule
`default_nettype wire

// File: rtl/rgb_frame_loader.sv
`default_nettype none
// ============================================================================
// Module   : rgb_frame_loader
// Purpose  : Packs received R,G,B bytes into pixel words and writes them to
//            the frame buffer in raster order, with frame-done tracking,
//            inter-byte timeout resync and a stretched activity LED.
// Revision : 1.0 - initial release
// ============================================================================
module rgb_frame_loader
    import rgb_frame_loader_pkg::*;
#(
    parameter int IMG_W         = DEFAULT_IMG_W,
    parameter int IMG_H         = DEFAULT_IMG_H,
    parameter int ADDR_W        = 15,
    parameter int COLOR_BITS    = DEFAULT_COLOR_BITS,
    parameter int TIMEOUT_CLKS  = 156240,
    parameter int LED_HOLD_CLKS = 2500000
) (
    input  logic              i_Clock,
    input  logic              i_Reset_n,
    rgb_frame_loader_if.slave bus
);

    localparam int c_PIX_W = pixel_width(COLOR_BITS);
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(frame_pixels(IMG_W, IMG_H) - 1);
    localparam int c_TMO_W = $clog2(TIMEOUT_CLKS);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CLKS - 1);

    logic [1:0]            r_rst_pipe;
    logic                  w_rst_n;
    state_t                r_state, w_state_next;
    logic [ADDR_W-1:0]     r_addr, w_addr_next;
    logic [COLOR_BITS-1:0] r_red, w_red_next;
    logic [COLOR_BITS-1:0] r_green, w_green_next;
    logic [COLOR_BITS-1:0] w_chan;
    logic [c_TMO_W-1:0]    r_tmo_cnt;
    logic                  r_wr_en;
    logic [ADDR_W-1:0]     r_wr_addr;
    logic [c_PIX_W-1:0]    r_wr_data;
    logic                  r_sync_err;
    logic                  w_busy;
    logic                  w_timeout;
    logic                  w_fire;

    // Reset asserts immediately, releases two clocks after the pin deasserts
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_rst_pipe <= 2'b00;
        end else begin
            r_rst_pipe <= {r_rst_pipe[0], 1'b1};
        end
    end

    assign w_rst_n   = r_rst_pipe[1];
    assign w_chan    = bus.i_Rx_Byte[7 -: COLOR_BITS];
    assign w_busy    = (r_state == RX_G) || (r_state == RX_B) ||
                       ((r_state == RX_R) && (r_addr != '0));
    // A byte arriving on the expiry cycle keeps the frame alive
    assign w_timeout = w_busy && !bus.i_Rx_DV && (r_tmo_cnt == c_TMO_LAST);

    // Next state: start beats a byte, a byte beats a timeout
    always_comb begin
        w_state_next = r_state;
        w_addr_next  = r_addr;
        w_red_next   = r_red;
        w_green_next = r_green;
        w_fire       = 1'b0;
        if (bus.i_Start) begin
            w_state_next = RX_R;
            w_addr_next  = '0;
        end else if (bus.i_Rx_DV) begin
            case (r_state)
                RX_R: begin
                    w_red_next   = w_chan;
                    w_state_next = RX_G;
                end
                RX_G: begin
                    w_green_next = w_chan;
                    w_state_next = RX_B;
                end
                RX_B: begin
                    w_fire = 1'b1;
                    if (r_addr == c_LAST_ADDR) begin
                        w_addr_next  = '0;
                        w_state_next = DONE;
                    end else begin
                        w_addr_next  = r_addr + ADDR_W'(1);
                        w_state_next = RX_R;
                    end
                end
                default: begin
                    // Frame complete: bytes are ignored until re-armed
                end
            endcase
        end else if (w_timeout) begin
            w_state_next = RX_R;
            w_addr_next  = '0;
        end
    end

    // State, address and channel holding registers
    always_ff @(posedge i_Clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= RX_R;
            r_addr  <= '0;
            r_red   <= '0;
            r_green <= '0;
        end else begin
            r_state <= w_state_next;
            r_addr  <= w_addr_next;
            r_red   <= w_red_next;
            r_green <= w_green_next;
        end
    end

    // Registered RAM write port; address/data hold between strobes
    always_ff @(posedge i_Clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_fire;
            if (w_fire) begin
                r_wr_addr <= r_addr;
                r_wr_data <= {r_red, r_green, w_chan};
            end
        end
    end

    // Idle counter: runs only mid-frame, cleared by any byte or restart
    always_ff @(posedge i_Clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_tmo_cnt <= '0;
        end else if (bus.i_Start || bus.i_Rx_DV || !w_busy || w_timeout) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
        end
    end

    // Sticky resync flag, cleared only by reset or start
    always_ff @(posedge i_Clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_sync_err <= 1'b0;
        end else if (bus.i_Start) begin
            r_sync_err <= 1'b0;
        end else if (w_timeout) begin
            r_sync_err <= 1'b1;
        end
    end

    activity_stretch #(
        .HOLD_CLKS (LED_HOLD_CLKS)
    ) u_led_stretch (
        .i_Clock   (i_Clock),
        .i_Reset_n (w_rst_n),
        .i_Pulse   (bus.i_Rx_DV),
        .o_Active  (bus.o_LED_Activity)
    );

    assign bus.o_Wr_En      = r_wr_en;
    assign bus.o_Wr_Addr    = r_wr_addr;
    assign bus.o_Wr_Data    = r_wr_data;
    assign bus.o_Busy       = w_busy;
    assign bus.o_Frame_Done = (r_state == DONE);
    assign bus.o_Sync_Err   = r_sync_err;

endmodule
`default_nettype wire

// File: tb/tb_rgb_frame_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_rgb_frame_loader
// Purpose  : Self-checking bench for rgb_frame_loader against a byte-level
//            reference model of the loader's behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rgb_frame_loader;

    localparam int IMG_W = 4;
    localparam int IMG_H = 2;
    localparam int ADDR_W = 3;
    localparam int COLOR_BITS = 4;
    localparam int TMO = 50;
    localparam int LED = 20;
    localparam int FRAME = IMG_W * IMG_H;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    // Reference model: bytes of the current pixel, pixel index, flags, counters
    int          m_cnt, m_pix, m_idle, m_led, m_r, m_g;
    bit          m_done, m_err;
    bit          exp_we;
    int          exp_wa;
    logic [11:0] exp_wd;

    always #5 clk = ~clk;

    rgb_frame_loader_if #(.ADDR_W(ADDR_W), .COLOR_BITS(COLOR_BITS)) bus ();

    rgb_frame_loader #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .COLOR_BITS(COLOR_BITS),
        .TIMEOUT_CLKS(TMO), .LED_HOLD_CLKS(LED)
    ) dut (
        .i_Clock   (clk),
        .i_Reset_n (rst_n),
        .bus       (bus)
    );

    task automatic model_reset();
        m_cnt = 0; m_pix = 0; m_idle = 0; m_led = 0; m_r = 0; m_g = 0;
        m_done = 0; m_err = 0; exp_we = 0; exp_wa = 0; exp_wd = '0;
    endtask

    // One clock edge of the specified behaviour, given the inputs it sampled
    task automatic model_step(input bit dv, input logic [7:0] b, input bit st);
        bit busy;
        busy = (m_cnt != 0) || (!m_done && m_pix != 0);
        exp_we = 0;
        if (dv) m_led = LED;
        else if (m_led > 0) m_led = m_led - 1;
        if (st) begin
            m_cnt = 0; m_pix = 0; m_done = 0; m_err = 0; m_idle = 0;
        end else if (dv) begin
            m_idle = 0;
            if (!m_done) begin
                if (m_cnt == 0) begin
                    m_r = int'(b) / 16; m_cnt = 1;
                end else if (m_cnt == 1) begin
                    m_g = int'(b) / 16; m_cnt = 2;
                end else begin
                    exp_we = 1;
                    exp_wa = m_pix;
                    exp_wd = 12'(m_r * 256 + m_g * 16 + int'(b) / 16);
                    m_cnt = 0;
                    if (m_pix == FRAME - 1) begin
                        m_pix = 0; m_done = 1;
                    end else begin
                        m_pix = m_pix + 1;
                    end
                end
            end
        end else if (busy) begin
            m_idle = m_idle + 1;
            if (m_idle == TMO) begin
                m_cnt = 0; m_pix = 0; m_err = 1; m_idle = 0;
            end
        end else begin
            m_idle = 0;
        end
    endtask

    // Drive one cycle of inputs, advance DUT and model, settle 1 ns past the edge
    task automatic cycle(input bit dv, input logic [7:0] b, input bit st);
        bus.i_Rx_DV = dv; bus.i_Rx_Byte = b; bus.i_Start = st;
        @(posedge clk);
        model_step(dv, b, st);
        #1;
        bus.i_Rx_DV = 1'b0; bus.i_Start = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] b;
        model_reset();
        #1;
        checks++;
        if ({bus.o_Wr_En, bus.o_Wr_Addr, bus.o_Wr_Data, bus.o_Busy, bus.o_Frame_Done,
             bus.o_Sync_Err, bus.o_LED_Activity} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got we=%b a=%0d d=%h busy=%b done=%b err=%b led=%b, need all 0",
                     bus.o_Wr_En, bus.o_Wr_Addr, bus.o_Wr_Data, bus.o_Busy,
                     bus.o_Frame_Done, bus.o_Sync_Err, bus.o_LED_Activity);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) cycle(0, 8'h00, 0);
        cycle(1, 8'($urandom), 0);
        cycle(1, 8'($urandom), 0);
        checks++;
        if (bus.o_Busy !== 1'b1 || bus.o_LED_Activity !== 1'b1) begin
            failures++;
            $display("FAIL reset_pre_busy: got busy=%b led=%b, need 1 1", bus.o_Busy, bus.o_LED_Activity);
        end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({bus.o_Wr_En, bus.o_Wr_Addr, bus.o_Wr_Data, bus.o_Busy, bus.o_Frame_Done,
             bus.o_Sync_Err, bus.o_LED_Activity} !== '0) begin
            failures++;
            $display("FAIL reset_async: got busy=%b led=%b we=%b, need all outputs 0",
                     bus.o_Busy, bus.o_LED_Activity, bus.o_Wr_En);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) cycle(0, 8'h00, 0);
        b = 8'($urandom); cycle(1, b, 0);
        b = 8'($urandom); cycle(1, b, 0);
        b = 8'($urandom); cycle(1, b, 0);
        checks++;
        if (bus.o_Wr_En !== 1'b1 || bus.o_Wr_Addr !== 3'(0) || bus.o_Wr_Data !== exp_wd) begin
            failures++;
            $display("FAIL reset_first_write: got we=%b a=%0d d=%h, need 1 0 %h",
                     bus.o_Wr_En, bus.o_Wr_Addr, bus.o_Wr_Data, exp_wd);
        end
    endtask

    task automatic test_single_pixel();
        cycle(0, 8'h00, 1);
        cycle(1, 8'hF0, 0);
        checks++;
        if (bus.o_Busy !== 1'b1 || bus.o_Wr_En !== 1'b0) begin
            failures++;
            $display("FAIL pixel_busy_r: got busy=%b we=%b, need 1 0", bus.o_Busy, bus.o_Wr_En);
        end
        cycle(1, 8'h80, 0);
        checks++;
        if (bus.o_Wr_En !== 1'b0) begin
            failures++;
            $display("FAIL pixel_early_we: got we=%b, need 0", bus.o_Wr_En);
        end
        cycle(1, 8'h3C, 0);
        checks++;
        if (bus.o_Wr_En !== 1'b1 || bus.o_Wr_Addr !== 3'(0) || bus.o_Wr_Data !== 12'hF83) begin
            failures++;
            $display("FAIL pixel_write: got we=%b a=%0d d=%h, need 1 0 f83",
                     bus.o_Wr_En, bus.o_Wr_Addr, bus.o_Wr_Data);
        end
        cycle(0, 8'h00, 0);
        checks++;
        if (bus.o_Wr_En !== 1'b0 || bus.o_Busy !== 1'b1 || bus.o_Wr_Data !== 12'hF83) begin
            failures++;
            $display("FAIL pixel_after: got we=%b busy=%b d=%h, need 0 1 f83",
                     bus.o_Wr_En, bus.o_Busy, bus.o_Wr_Data);
        end
    endtask

    task automatic test_full_frame();
        int nwr;
        nwr = 0;
        cycle(0, 8'h00, 1);
        for (int i = 0; i < 3 * FRAME; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g <= gap; g++) begin
                cycle(g == gap, 8'($urandom), 0);
                checks++;
                if (bus.o_Wr_En !== exp_we || bus.o_Busy !== (m_cnt != 0 || m_pix != 0) ||
                    bus.o_Frame_Done !== m_done) begin
                    failures++;
                    $display("FAIL frame_ctrl: byte %0d got we=%b busy=%b done=%b, need %b %b %b",
                             i, bus.o_Wr_En, bus.o_Busy, bus.o_Frame_Done, exp_we,
                             (m_cnt != 0 || m_pix != 0), m_done);
                end
                if (exp_we) begin
                    checks++;
                    if (bus.o_Wr_Addr !== 3'(nwr) || bus.o_Wr_Data !== exp_wd) begin
                        failures++;
                        $display("FAIL frame_write: got a=%0d d=%h, need %0d %h",
                                 bus.o_Wr_Addr, bus.o_Wr_Data, nwr, exp_wd);
                    end
                end
                if (bus.o_Wr_En === 1'b1) nwr++;
            end
        end
        checks++;
        if (nwr != FRAME || bus.o_Frame_Done !== 1'b1) begin
            failures++;
            $display("FAIL frame_count: got writes=%0d done=%b, need %0d 1", nwr, bus.o_Frame_Done, FRAME);
        end
        cycle(1, 8'($urandom), 0);
        checks++;
        if (bus.o_Wr_En !== 1'b0 || bus.o_LED_Activity !== 1'b1 || bus.o_Frame_Done !== 1'b1) begin
            failures++;
            $display("FAIL frame_extra_byte: got we=%b led=%b done=%b, need 0 1 1",
                     bus.o_Wr_En, bus.o_LED_Activity, bus.o_Frame_Done);
        end
        cycle(0, 8'h00, 0);
        checks++;
        if (bus.o_Wr_En !== 1'b0) begin
            failures++;
            $display("FAIL frame_extra_late_we: got we=%b, need 0", bus.o_Wr_En);
        end
        cycle(0, 8'h00, 1);
        checks++;
        if (bus.o_Frame_Done !== 1'b0 || bus.o_Busy !== 1'b0) begin
            failures++;
            $display("FAIL frame_restart: got done=%b busy=%b, need 0 0", bus.o_Frame_Done, bus.o_Busy);
        end
    endtask

    task automatic test_timeout();
        int nwr;
        nwr = 0;
        cycle(0, 8'h00, 1);
        repeat (7) cycle(1, 8'($urandom), 0);
        for (int i = 0; i < 60; i++) begin
            cycle(0, 8'h00, 0);
            checks++;
            if (bus.o_Sync_Err !== m_err || bus.o_Busy !== (m_cnt != 0 || m_pix != 0)) begin
                failures++;
                $display("FAIL timeout_track: idle %0d got err=%b busy=%b, need %b %b",
                         i, bus.o_Sync_Err, bus.o_Busy, m_err, (m_cnt != 0 || m_pix != 0));
            end
            if (bus.o_Wr_En === 1'b1) nwr++;
        end
        checks++;
        if (bus.o_Sync_Err !== 1'b1 || bus.o_Busy !== 1'b0 || nwr != 0) begin
            failures++;
            $display("FAIL timeout_end: got err=%b busy=%b writes=%0d, need 1 0 0",
                     bus.o_Sync_Err, bus.o_Busy, nwr);
        end
        repeat (3) cycle(1, 8'($urandom), 0);
        checks++;
        if (bus.o_Wr_En !== 1'b1 || bus.o_Wr_Addr !== 3'(0) || bus.o_Wr_Data !== exp_wd ||
            bus.o_Sync_Err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_resync_write: got we=%b a=%0d d=%h err=%b, need 1 0 %h 1",
                     bus.o_Wr_En, bus.o_Wr_Addr, bus.o_Wr_Data, bus.o_Sync_Err, exp_wd);
        end
        cycle(0, 8'h00, 1);
        checks++;
        if (bus.o_Sync_Err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_err_clear: got err=%b, need 0", bus.o_Sync_Err);
        end
    endtask

    task automatic test_collisions();
        // Start together with a byte: the byte is dropped
        cycle(0, 8'h00, 1);
        cycle(1, 8'hAA, 1);
        checks++;
        if (bus.o_Busy !== 1'b0) begin
            failures++;
            $display("FAIL coll_start_dv_busy: got busy=%b, need 0", bus.o_Busy);
        end
        cycle(1, 8'h12, 0);
        cycle(1, 8'h34, 0);
        cycle(1, 8'h56, 0);
        checks++;
        if (bus.o_Wr_En !== 1'b1 || bus.o_Wr_Addr !== 3'(0) || bus.o_Wr_Data !== 12'h135) begin
            failures++;
            $display("FAIL coll_start_dv_write: got we=%b a=%0d d=%h, need 1 0 135",
                     bus.o_Wr_En, bus.o_Wr_Addr, bus.o_Wr_Data);
        end
        // Start while the write strobe is high: write stands, frame restarts
        cycle(0, 8'h00, 1);
        checks++;
        if (bus.o_Wr_En !== 1'b0 || bus.o_Busy !== 1'b0) begin
            failures++;
            $display("FAIL coll_start_on_we: got we=%b busy=%b, need 0 0", bus.o_Wr_En, bus.o_Busy);
        end
        cycle(1, 8'h9F, 0);
        cycle(1, 8'h6F, 0);
        cycle(1, 8'hE0, 0);
        checks++;
        if (bus.o_Wr_En !== 1'b1 || bus.o_Wr_Addr !== 3'(0) || bus.o_Wr_Data !== 12'h96E) begin
            failures++;
            $display("FAIL coll_restart_write: got we=%b a=%0d d=%h, need 1 0 96e",
                     bus.o_Wr_En, bus.o_Wr_Addr, bus.o_Wr_Data);
        end
        // Byte exactly on the expiry cycle keeps the frame
        cycle(0, 8'h00, 1);
        cycle(1, 8'($urandom), 0);
        repeat (TMO - 1) cycle(0, 8'h00, 0);
        checks++;
        if (bus.o_Sync_Err !== 1'b0) begin
            failures++;
            $display("FAIL coll_pre_expiry: got err=%b, need 0", bus.o_Sync_Err);
        end
        cycle(1, 8'($urandom), 0);
        checks++;
        if (bus.o_Sync_Err !== 1'b0 || bus.o_Busy !== 1'b1) begin
            failures++;
            $display("FAIL coll_dv_on_expiry: got err=%b busy=%b, need 0 1", bus.o_Sync_Err, bus.o_Busy);
        end
        // Without that byte, the same idle length does expire
        repeat (TMO - 1) cycle(0, 8'h00, 0);
        checks++;
        if (bus.o_Sync_Err !== 1'b0) begin
            failures++;
            $display("FAIL coll_expiry_early: got err=%b, need 0", bus.o_Sync_Err);
        end
        cycle(0, 8'h00, 0);
        checks++;
        if (bus.o_Sync_Err !== 1'b1 || bus.o_Busy !== 1'b0) begin
            failures++;
            $display("FAIL coll_expiry: got err=%b busy=%b, need 1 0", bus.o_Sync_Err, bus.o_Busy);
        end
    endtask

    task automatic test_led_stretch();
        int high;
        cycle(0, 8'h00, 1);
        repeat (LED + 5) cycle(0, 8'h00, 0);
        checks++;
        if (bus.o_LED_Activity !== 1'b0) begin
            failures++;
            $display("FAIL led_idle: got led=%b, need 0", bus.o_LED_Activity);
        end
        high = 0;
        for (int i = 0; i < 30; i++) begin
            cycle(i == 0, 8'($urandom), 0);
            if (bus.o_LED_Activity === 1'b1) high++;
        end
        checks++;
        if (high != 20) begin
            failures++;
            $display("FAIL led_single: got high clocks=%0d, need 20", high);
        end
        cycle(0, 8'h00, 1);
        repeat (LED + 5) cycle(0, 8'h00, 0);
        high = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(i == 0 || i == 10, 8'($urandom), 0);
            checks++;
            if (bus.o_LED_Activity !== (i < 30)) begin
                failures++;
                $display("FAIL led_retrigger: clock %0d got led=%b, need %b", i, bus.o_LED_Activity, (i < 30));
            end
            if (bus.o_LED_Activity === 1'b1) high++;
        end
        checks++;
        if (high != 30) begin
            failures++;
            $display("FAIL led_retrigger_len: got high clocks=%0d, need 30", high);
        end
    endtask

    task automatic test_random();
        cycle(0, 8'h00, 1);
        for (int i = 0; i < 600; i++) begin
            bit dv, st;
            if ($urandom_range(0, 49) == 0) begin
                repeat ($urandom_range(TMO - 2, TMO + 3)) cycle(0, 8'h00, 0);
            end
            dv = ($urandom_range(0, 1) == 1);
            st = ($urandom_range(0, 59) == 0);
            cycle(dv, 8'($urandom), st);
            checks++;
            if (bus.o_Wr_En !== exp_we || bus.o_Busy !== (m_cnt != 0 || m_pix != 0) ||
                bus.o_Frame_Done !== m_done || bus.o_Sync_Err !== m_err ||
                bus.o_LED_Activity !== (m_led != 0) || bus.o_Wr_Addr !== 3'(exp_wa) ||
                bus.o_Wr_Data !== exp_wd) begin
                failures++;
                $display("FAIL random_step %0d: got we=%b a=%0d d=%h busy=%b done=%b err=%b led=%b, need %b %0d %h %b %b %b %b",
                         i, bus.o_Wr_En, bus.o_Wr_Addr, bus.o_Wr_Data, bus.o_Busy, bus.o_Frame_Done,
                         bus.o_Sync_Err, bus.o_LED_Activity, exp_we, exp_wa, exp_wd,
                         (m_cnt != 0 || m_pix != 0), m_done, m_err, (m_led != 0));
            end
        end
    endtask

    initial begin
        bus.i_Rx_DV = 1'b0;
        bus.i_Rx_Byte = 8'h00;
        bus.i_Start = 1'b0;
        test_reset();
        test_single_pixel();
        test_full_frame();
        test_timeout();
        test_collisions();
        test_led_stretch();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
